uart_cmd_responder: RTL and testbench
=====================================

// Module: uart_cmd_responder
// PURPOSE
//  Byte-level command responder on the user side of the UART core.
//  Consumes received bytes (uart data_out/data_ready), parses 2/3-byte register commands,
//  updates a local register file, and returns one response byte through the transmitter (data_in/send/busy).
//  Gives a host PC read/write access to 2**ADDR_W control registers over the serial link.
// PARAMETERS
//  ADDR_W       4       register address width; NREGS = 2**ADDR_W 8-bit registers
//  TIMEOUT_CYC  100000  idle clk cycles allowed between bytes of one command before the partial command is dropped
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          asynchronous, active-high reset
//  rx_data    in   8          received byte (from uart data_out)
//  rx_ready   in   1          received-byte strobe/level (from uart data_ready)
//  tx_data    out  8          response byte (to uart data_in)
//  tx_send    out  1          one-cycle transmit request (to uart send)
//  tx_busy    in   1          transmitter busy (from uart busy)
//  regs_flat  out  8*NREGS    register file; reg i = regs_flat[8*i+7:8*i]
//  overrun    out  1          sticky: a byte arrived while a response was in flight
//  timeout    out  1          one-cycle pulse when a partial command is discarded
// BEHAVIOUR
//  Reset: all registers 0x00, tx_data=0x00, tx_send=0, overrun=0, timeout=0, state IDLE.
//  - rst asserted mid-operation aborts any command/response immediately; tx_send forced 0.
//  Byte capture: new byte = rising edge of rx_ready (registered previous value, reset 0).
//  - rx_ready held high counts once.
//  - rx_data is sampled in the same cycle as the edge.
//  Commands:
//  - 'W'(0x57), addr, data: write, respond 'K'(0x4B).
//  - 'R'(0x52), addr: read, respond with register value.
//  - Any other first byte: respond '?'(0x3F); no further bytes consumed.
//  - addr[7:ADDR_W] != 0: respond '!'(0x21).
//    * For 'W', the data byte is still consumed and discarded; no register changes.
//  States:
//  - IDLE -new byte-> GET_ADDR ('W'/'R') or LOAD ('?').
//  - GET_ADDR -new byte-> GET_DATA ('W') or LOAD ('R').
//  - GET_DATA -new byte-> LOAD; the register write happens on this edge for a valid address.
//  - LOAD: drive tx_data, wait for tx_busy==0, then pulse tx_send for exactly 1 cycle -> WAIT_HI.
//  - WAIT_HI: hold tx_data until tx_busy==1 -> WAIT_LO.
//    * tx_busy rises only at the next tx_en tick, so this wait is required.
//  - WAIT_LO: tx_busy==0 -> IDLE.
//  - tx_data stays stable from LOAD until WAIT_LO exits.
//  Latency: the response tx_send pulse occurs 1 cycle after the final command byte edge, provided tx_busy is 0.
//  A read returns the value as it is at the final byte edge.
//  Timeout: in GET_ADDR/GET_DATA, a 32-bit cycle counter resets on every new byte.
//  - When the counter reaches TIMEOUT_CYC-1: pulse timeout, return to IDLE, send no response.
//  Overrun: a new byte edge in LOAD/WAIT_HI/WAIT_LO sets overrun (sticky until rst).
//  - The byte is dropped and not parsed.
//  Simultaneous timeout expiry and new byte: the byte wins, the counter clears, parsing continues.
//  Register write and regs_flat update: visible the cycle after the data byte edge.
// TESTING
//  1. Send 0x57,0x03,0xA5 -> regs_flat[31:24]=0xA5; one tx_send pulse with tx_data=0x4B.
//  2. After test 1, send 0x52,0x03 -> tx_data=0xA5 with a single tx_send pulse; no register changes.
//  3. Send 0x41 -> response 0x3F; next byte 0x52 begins a new command (0x52,0x00 -> 0x00).
//  4. Send 0x57,0x10,0x55 (ADDR_W=4) -> response 0x21; all regs unchanged.
//  5. Send 0x57 then nothing for TIMEOUT_CYC cycles -> timeout pulse, no tx_send; then 0x52,0x03 -> normal reply.
//  6. Hold tx_busy high, complete 0x52,0x00, inject a byte during the wait -> overrun=1, single response only.
//     Also assert rst mid-frame -> all outputs back to reset values.

Source files
------------

// File: rtl/uart_cmd_responder.sv
// Parses 'W' addr data / 'R' addr byte commands into a local register file and answers each command with one byte.
// Response tx_send is combinational from LOAD so it lands one cycle after the final command byte edge.
module uart_cmd_responder #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_ready,
    output logic [7:0]                  tx_data,
    output logic                        tx_send,
    input  logic                        tx_busy,
    output logic [8*(2**ADDR_W)-1:0]    regs_flat,
    output logic                        overrun,
    output logic                        timeout
);

    localparam int NREGS = 2**ADDR_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_LOAD     = 3'd3;
    localparam logic [2:0] S_WAIT_HI  = 3'd4;
    localparam logic [2:0] S_WAIT_LO  = 3'd5;

    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_QM   = 8'h3F;
    localparam logic [7:0] CH_BANG = 8'h21;

    logic [2:0]         state;
    logic               rx_ready_q;
    logic               new_byte;
    logic               cmd_wr;
    logic               addr_ok_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        idle_cnt;
    logic [7:0]         regs [NREGS];
    logic               rx_addr_ok;

    assign new_byte   = rx_ready && !rx_ready_q;
    assign rx_addr_ok = ((rx_data >> ADDR_W) == 8'd0);
    assign tx_send    = (state == S_LOAD) && !tx_busy;

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            rx_ready_q <= 1'b0;
            cmd_wr     <= 1'b0;
            addr_ok_q  <= 1'b0;
            addr_q     <= '0;
            idle_cnt   <= '0;
            tx_data    <= 8'h00;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            rx_ready_q <= rx_ready;
            timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (new_byte) begin
                        idle_cnt <= '0;
                        cmd_wr   <= (rx_data == CH_W);
                        if (rx_data == CH_W || rx_data == CH_R) begin
                            state <= S_GET_ADDR;
                        end else begin
                            tx_data <= CH_QM;
                            state   <= S_LOAD;
                        end
                    end
                end
                S_GET_ADDR, S_GET_DATA: begin
                    // A byte arriving on the expiry cycle takes priority over the timeout.
                    if (new_byte) begin
                        idle_cnt <= '0;
                        if (state == S_GET_ADDR) begin
                            addr_q    <= rx_data[ADDR_W-1:0];
                            addr_ok_q <= rx_addr_ok;
                            if (cmd_wr) begin
                                state <= S_GET_DATA;
                            end else begin
                                tx_data <= rx_addr_ok ? regs[rx_data[ADDR_W-1:0]] : CH_BANG;
                                state   <= S_LOAD;
                            end
                        end else begin
                            if (addr_ok_q) begin
                                regs[addr_q] <= rx_data;
                            end
                            tx_data <= addr_ok_q ? CH_K : CH_BANG;
                            state   <= S_LOAD;
                        end
                    end else if (idle_cnt == 32'(TIMEOUT_CYC - 1)) begin
                        timeout <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                S_LOAD: begin
                    if (!tx_busy) begin
                        state <= S_WAIT_HI;
                    end
                end
                // The transmitter only raises busy on its next baud tick, so wait to see it high first.
                S_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (new_byte && (state == S_LOAD || state == S_WAIT_HI || state == S_WAIT_LO)) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Vector table plus randomized commands against a register-array model of the command protocol.
module tb_uart_cmd_responder;

    localparam int TO = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_ready;
    logic [7:0]   tx_data;
    logic         tx_send;
    logic         tx_busy;
    logic [127:0] regs_flat;
    logic         overrun;
    logic         timeout;

    logic         uart_busy = 1'b0;
    logic         hold_busy = 1'b0;
    assign tx_busy = uart_busy | hold_busy;

    uart_cmd_responder #(.ADDR_W(4), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
        .regs_flat(regs_flat), .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sends  = 0;
    int to_cnt = 0;
    logic [7:0] last_resp = 8'h00;
    logic [7:0] mregs [16];

    typedef struct {
        logic [7:0] b0, b1, b2;
        logic [7:0] exp_resp;
        int         reg_idx;
        logic [7:0] exp_reg;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every response byte and timeout pulse, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                sends++;
                last_resp = tx_data;
            end
            if (timeout === 1'b1) to_cnt++;
        end
    end

    // Transmitter model: busy rises a couple of cycles after send, stays up a while.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                tick();
                tick();
                uart_busy = 1'b1;
                repeat (5) tick();
                uart_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic int nbytes(input logic [7:0] b0);
        return (b0 == 8'h57) ? 3 : (b0 == 8'h52) ? 2 : 1;
    endfunction

    function automatic logic [7:0] model_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        if (b0 == 8'h57) begin
            if (b1 > 8'd15) return 8'h21;
            mregs[b1] = b2;
            return 8'h4B;
        end
        if (b0 == 8'h52) return (b1 > 8'd15) ? 8'h21 : mregs[b1];
        return 8'h3F;
    endfunction

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = mregs[i];
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int hold);
        tick();
        rx_data  = b;
        rx_ready = 1'b1;
        repeat (hold) tick();
        rx_ready = 1'b0;
    endtask

    task automatic wait_resp(input int s0, output logic [7:0] got, output int nresp);
        for (int i = 0; i < 200 && sends == s0; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (15) tick();
        got   = last_resp;
        nresp = sends - s0;
    endtask

    task automatic run_cmd(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           output logic [7:0] got, output int nresp);
        int s0;
        int n;
        s0 = sends;
        n  = nbytes(b0);
        send_byte(b0, 1);
        if (n > 1) send_byte(b1, 1);
        if (n > 2) send_byte(b2, 1);
        wait_resp(s0, got, nresp);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] exp;
        logic [7:0] b0, b1, b2;
        int nresp;
        int s0;
        int to0;
        int first_to;

        vecs[0] = '{8'h57, 8'h03, 8'hA5, 8'h4B, 3,  8'hA5};
        vecs[1] = '{8'h52, 8'h03, 8'h00, 8'hA5, 3,  8'hA5};
        vecs[2] = '{8'h41, 8'h00, 8'h00, 8'h3F, 3,  8'hA5};
        vecs[3] = '{8'h52, 8'h00, 8'h00, 8'h00, 0,  8'h00};
        vecs[4] = '{8'h57, 8'h10, 8'h55, 8'h21, 0,  8'h00};
        vecs[5] = '{8'h52, 8'h20, 8'h00, 8'h21, 3,  8'hA5};
        vecs[6] = '{8'h57, 8'h0F, 8'h7E, 8'h4B, 15, 8'h7E};
        vecs[7] = '{8'h52, 8'h0F, 8'h00, 8'h7E, 15, 8'h7E};
        vecs[8] = '{8'h57, 8'hFF, 8'h11, 8'h21, 15, 8'h7E};

        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("reset_regs", regs_flat, 128'h0);
        chk("reset_tx_data", {120'h0, tx_data}, 128'h0);
        chk("reset_tx_send", {127'h0, tx_send}, 128'h0);
        chk("reset_overrun", {127'h0, overrun}, 128'h0);
        chk("reset_timeout", {127'h0, timeout}, 128'h0);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2, got, nresp);
            void'(model_cmd(vecs[i].b0, vecs[i].b1, vecs[i].b2));
            chk($sformatf("vec%0d_count", i), 128'(nresp), 128'd1);
            chk($sformatf("vec%0d_resp", i), {120'h0, got}, {120'h0, vecs[i].exp_resp});
            chk($sformatf("vec%0d_reg", i), {120'h0, regs_flat[8*vecs[i].reg_idx +: 8]}, {120'h0, vecs[i].exp_reg});
            chk($sformatf("vec%0d_all_regs", i), regs_flat, mflat());
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            b0  = (sel < 4) ? 8'h57 : (sel < 8) ? 8'h52 : 8'($urandom_range(0, 255));
            b1  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            b2  = 8'($urandom_range(0, 255));
            run_cmd(b0, b1, b2, got, nresp);
            exp = model_cmd(b0, b1, b2);
            chk($sformatf("rand%0d_count", i), 128'(nresp), 128'd1);
            chk($sformatf("rand%0d_resp", i), {120'h0, got}, {120'h0, exp});
            chk($sformatf("rand%0d_regs", i), regs_flat, mflat());
        end

        // Abandoned write: exactly one timeout pulse near TO cycles, no response.
        s0       = sends;
        to0      = to_cnt;
        first_to = -1;
        send_byte(8'h57, 1);
        for (int i = 1; i <= TO + 20; i++) begin
            @(negedge clk);
            #1;
            if (timeout === 1'b1 && first_to < 0) first_to = i;
        end
        chk("timeout_pulses", 128'(to_cnt - to0), 128'd1);
        chk("timeout_no_send", 128'(sends - s0), 128'd0);
        chk("timeout_not_early", 128'(first_to >= TO - 3), 128'd1);
        chk("timeout_not_late", 128'(first_to <= TO + 3), 128'd1);
        run_cmd(8'h52, 8'h03, 8'h00, got, nresp);
        chk("after_timeout_resp", {120'h0, got}, {120'h0, model_cmd(8'h52, 8'h03, 8'h00)});
        chk("after_timeout_count", 128'(nresp), 128'd1);

        // A byte shortly before expiry keeps the command alive.
        s0  = sends;
        to0 = to_cnt;
        send_byte(8'h52, 1);
        repeat (TO - 5) tick();
        send_byte(8'h0F, 1);
        wait_resp(s0, got, nresp);
        chk("keepalive_resp", {120'h0, got}, {120'h0, model_cmd(8'h52, 8'h0F, 8'h00)});
        chk("keepalive_no_timeout", 128'(to_cnt - to0), 128'd0);

        // rx_ready held high for several cycles is a single byte.
        s0 = sends;
        send_byte(8'h52, 6);
        send_byte(8'h03, 4);
        wait_resp(s0, got, nresp);
        chk("level_hold_resp", {120'h0, got}, {120'h0, model_cmd(8'h52, 8'h03, 8'h00)});
        chk("level_hold_count", 128'(nresp), 128'd1);

        // Busy transmitter: response waits, stray byte flags overrun and is dropped.
        chk("overrun_clear_before", {127'h0, overrun}, 128'h0);
        hold_busy = 1'b1;
        s0 = sends;
        send_byte(8'h52, 1);
        send_byte(8'h00, 1);
        repeat (10) tick();
        chk("busy_hold_no_send", 128'(sends - s0), 128'd0);
        send_byte(8'h57, 1);
        tick();
        chk("overrun_set", {127'h0, overrun}, 128'h1);
        hold_busy = 1'b0;
        wait_resp(s0, got, nresp);
        repeat (20) tick();
        nresp = sends - s0;
        chk("overrun_resp", {120'h0, got}, {120'h0, model_cmd(8'h52, 8'h00, 8'h00)});
        chk("overrun_single_resp", 128'(nresp), 128'd1);
        chk("overrun_sticky", {127'h0, overrun}, 128'h1);
        run_cmd(8'h52, 8'h03, 8'h00, got, nresp);
        chk("after_overrun_resp", {120'h0, got}, {120'h0, model_cmd(8'h52, 8'h03, 8'h00)});

        // Reset in the middle of a write command.
        send_byte(8'h57, 1);
        send_byte(8'h05, 1);
        tick();
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        chk("midrst_regs", regs_flat, 128'h0);
        chk("midrst_tx_data", {120'h0, tx_data}, 128'h0);
        chk("midrst_tx_send", {127'h0, tx_send}, 128'h0);
        chk("midrst_overrun", {127'h0, overrun}, 128'h0);
        chk("midrst_timeout", {127'h0, timeout}, 128'h0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();
        run_cmd(8'h52, 8'h05, 8'h00, got, nresp);
        chk("post_rst_read", {120'h0, got}, 128'h0);
        chk("post_rst_count", 128'(nresp), 128'd1);
        chk("post_rst_regs", regs_flat, mflat());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
